// File: rtl/multi_port_register_file_pkg.sv
// Shared sizing for the register file / rename-status table.
// Lane slicing helpers used by the top and the read ports.
package multi_port_register_file_pkg;

    localparam int XLEN      = 32;
    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;
    localparam int ROB_IDX_W = 4;
    localparam int ISSUE_W   = 2;
    localparam int COMMIT_W  = 2;
    localparam int RD_SLOTS  = 2 * ISSUE_W;
    localparam int BUSY_W    = REG_IDX_W + 1;

    function automatic int reg_lsb(input int lane);
        return lane * REG_IDX_W;
    endfunction

    function automatic int tag_lsb(input int lane);
        return lane * ROB_IDX_W;
    endfunction

    function automatic int val_lsb(input int lane);
        return lane * XLEN;
    endfunction

endpackage

// File: rtl/multi_port_register_file_rf_read_port.sv
// One source-operand lookup: stored state, intra-bundle rename
// forward and (with RF_COMMIT_BYPASS_EN) same-cycle commit bypass.
module rf_read_port
    import multi_port_register_file_pkg::*;
#(
    parameter int LANE = 0
) (
    input  logic [REG_IDX_W-1:0]         idx_i,
    input  logic [XLEN-1:0]              st_val_i,
    input  logic [ROB_IDX_W-1:0]         st_dep_i,
    input  logic                         st_has_dep_i,
    input  logic [ISSUE_W-1:0]           iss_valid_i,
    input  logic [ISSUE_W*REG_IDX_W-1:0] iss_rd_i,
    input  logic [ISSUE_W*ROB_IDX_W-1:0] iss_tag_i,
    input  logic [COMMIT_W-1:0]          cmt_valid_i,
    input  logic [COMMIT_W*REG_IDX_W-1:0] cmt_rd_i,
    input  logic [COMMIT_W*XLEN-1:0]     cmt_val_i,
    input  logic [COMMIT_W*ROB_IDX_W-1:0] cmt_tag_i,
    output logic [XLEN-1:0]              val_o,
    output logic [ROB_IDX_W-1:0]         dep_o,
    output logic                         has_dep_o
);

`ifndef RF_COMMIT_BYPASS_EN
    logic unused_cmt;
    assign unused_cmt = ^{cmt_valid_i, cmt_rd_i, cmt_val_i, cmt_tag_i};
`endif

    // Base lookup, then bypass, then older-lane forward; x0 wins last.
    always_comb begin
        val_o     = st_val_i;
        dep_o     = st_dep_i;
        has_dep_o = st_has_dep_i;
`ifdef RF_COMMIT_BYPASS_EN
        for (int c = 0; c < COMMIT_W; c++) begin
            if (cmt_valid_i[c] && st_has_dep_i &&
                cmt_rd_i[reg_lsb(c) +: REG_IDX_W] == idx_i &&
                cmt_tag_i[tag_lsb(c) +: ROB_IDX_W] == st_dep_i) begin
                val_o     = cmt_val_i[val_lsb(c) +: XLEN];
                has_dep_o = 1'b0;
            end
        end
`endif
        for (int j = 0; j < ISSUE_W; j++) begin
            if (j < LANE && iss_valid_i[j] &&
                iss_rd_i[reg_lsb(j) +: REG_IDX_W] == idx_i &&
                iss_rd_i[reg_lsb(j) +: REG_IDX_W] != '0) begin
                dep_o     = iss_tag_i[tag_lsb(j) +: ROB_IDX_W];
                has_dep_o = 1'b1;
            end
        end
        if (idx_i == '0) begin
            val_o     = '0;
            dep_o     = '0;
            has_dep_o = 1'b0;
        end
    end

endmodule

// File: rtl/multi_port_register_file.sv
// Architectural register file with ROB-tag rename status.
// Optional macro RF_COMMIT_BYPASS_EN: same-cycle commit bypass on reads.
module multi_port_register_file
    import multi_port_register_file_pkg::*;
(
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          clear,
    input  logic [RD_SLOTS*REG_IDX_W-1:0] rs_id,
    output logic [RD_SLOTS*XLEN-1:0]      rs_val,
    output logic [RD_SLOTS*ROB_IDX_W-1:0] rs_dep,
    output logic [RD_SLOTS-1:0]           rs_has_dep,
    input  logic [ISSUE_W-1:0]            iss_valid,
    input  logic [ISSUE_W*REG_IDX_W-1:0]  iss_rd,
    input  logic [ISSUE_W*ROB_IDX_W-1:0]  iss_tag,
    input  logic [COMMIT_W-1:0]           cmt_valid,
    input  logic [COMMIT_W*REG_IDX_W-1:0] cmt_rd,
    input  logic [COMMIT_W*XLEN-1:0]      cmt_val,
    input  logic [COMMIT_W*ROB_IDX_W-1:0] cmt_tag,
    output logic [BUSY_W-1:0]             busy_cnt
);

    logic [XLEN-1:0]      val_q [NUM_REGS];
    logic [XLEN-1:0]      val_d [NUM_REGS];
    logic [ROB_IDX_W-1:0] dep_q [NUM_REGS];
    logic [ROB_IDX_W-1:0] dep_d [NUM_REGS];
    logic [NUM_REGS-1:0]  hd_q;
    logic [NUM_REGS-1:0]  hd_d;
    logic [BUSY_W-1:0]    busy_q;
    logic [BUSY_W-1:0]    busy_d;

    // Commits first, then flush or issues; issue overriding a
    // commit-clear on the same rd falls out of this ordering.
    always_comb begin
        logic [REG_IDX_W-1:0] rd;
        val_d = val_q;
        dep_d = dep_q;
        hd_d  = hd_q;
        rd    = '0;
        for (int c = 0; c < COMMIT_W; c++) begin
            rd = cmt_rd[reg_lsb(c) +: REG_IDX_W];
            if (cmt_valid[c] && rd != '0) begin
                val_d[rd] = cmt_val[val_lsb(c) +: XLEN];
                if (hd_q[rd] &&
                    dep_q[rd] == cmt_tag[tag_lsb(c) +: ROB_IDX_W]) begin
                    hd_d[rd]  = 1'b0;
                    dep_d[rd] = '0;
                end
            end
        end
        if (clear) begin
            hd_d = '0;
            for (int r = 0; r < NUM_REGS; r++) dep_d[r] = '0;
        end else begin
            for (int j = 0; j < ISSUE_W; j++) begin
                rd = iss_rd[reg_lsb(j) +: REG_IDX_W];
                if (iss_valid[j] && rd != '0) begin
                    dep_d[rd] = iss_tag[tag_lsb(j) +: ROB_IDX_W];
                    hd_d[rd]  = 1'b1;
                end
            end
        end
    end

    // Population count of the next has_dep vector.
    always_comb begin
        busy_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_d = busy_d + BUSY_W'(hd_d[r]);
        end
    end

    // Table and busy count update together; rdy_in low freezes both.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                val_q[r] <= '0;
                dep_q[r] <= '0;
            end
            hd_q   <= '0;
            busy_q <= '0;
        end else if (rdy_in) begin
            val_q  <= val_d;
            dep_q  <= dep_d;
            hd_q   <= hd_d;
            busy_q <= busy_d;
        end
    end

    assign busy_cnt = busy_q;

    for (genvar s = 0; s < RD_SLOTS; s++) begin : g_rd
        logic [REG_IDX_W-1:0] idx;
        assign idx = rs_id[s*REG_IDX_W +: REG_IDX_W];
        rf_read_port #(.LANE(s / 2)) u_port (
            .idx_i        (idx),
            .st_val_i     (val_q[idx]),
            .st_dep_i     (dep_q[idx]),
            .st_has_dep_i (hd_q[idx]),
            .iss_valid_i  (iss_valid),
            .iss_rd_i     (iss_rd),
            .iss_tag_i    (iss_tag),
            .cmt_valid_i  (cmt_valid),
            .cmt_rd_i     (cmt_rd),
            .cmt_val_i    (cmt_val),
            .cmt_tag_i    (cmt_tag),
            .val_o        (rs_val[s*XLEN +: XLEN]),
            .dep_o        (rs_dep[s*ROB_IDX_W +: ROB_IDX_W]),
            .has_dep_o    (rs_has_dep[s])
        );
    end

endmodule

// File: tb/tb_multi_port_register_file.sv
// Directed scenarios plus random traffic against a behavioural
// register-file model.
module tb_multi_port_register_file;
    import multi_port_register_file_pkg::*;

    logic                          clk_in = 1'b0;
    logic                          rst_in;
    logic                          rdy_in;
    logic                          clear;
    logic [RD_SLOTS*REG_IDX_W-1:0] rs_id;
    logic [RD_SLOTS*XLEN-1:0]      rs_val;
    logic [RD_SLOTS*ROB_IDX_W-1:0] rs_dep;
    logic [RD_SLOTS-1:0]           rs_has_dep;
    logic [ISSUE_W-1:0]            iss_valid;
    logic [ISSUE_W*REG_IDX_W-1:0]  iss_rd;
    logic [ISSUE_W*ROB_IDX_W-1:0]  iss_tag;
    logic [COMMIT_W-1:0]           cmt_valid;
    logic [COMMIT_W*REG_IDX_W-1:0] cmt_rd;
    logic [COMMIT_W*XLEN-1:0]      cmt_val;
    logic [COMMIT_W*ROB_IDX_W-1:0] cmt_tag;
    logic [BUSY_W-1:0]             busy_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [XLEN-1:0]      m_val [NUM_REGS];
    logic [ROB_IDX_W-1:0] m_dep [NUM_REGS];
    logic                 m_hd  [NUM_REGS];

    multi_port_register_file dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .clear      (clear),
        .rs_id      (rs_id),
        .rs_val     (rs_val),
        .rs_dep     (rs_dep),
        .rs_has_dep (rs_has_dep),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .iss_tag    (iss_tag),
        .cmt_valid  (cmt_valid),
        .cmt_rd     (cmt_rd),
        .cmt_val    (cmt_val),
        .cmt_tag    (cmt_tag),
        .busy_cnt   (busy_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
        rs_id = '0; iss_valid = '0; iss_rd = '0; iss_tag = '0;
        cmt_valid = '0; cmt_rd = '0; cmt_val = '0; cmt_tag = '0;
    endtask

    task automatic rs(input int s, input int r);
        rs_id[s*REG_IDX_W +: REG_IDX_W] = REG_IDX_W'(r);
    endtask

    task automatic iss(input int l, input int r, input int t);
        iss_valid[l] = 1'b1;
        iss_rd[l*REG_IDX_W +: REG_IDX_W] = REG_IDX_W'(r);
        iss_tag[l*ROB_IDX_W +: ROB_IDX_W] = ROB_IDX_W'(t);
    endtask

    task automatic cmt(input int l, input int r, input int t,
                       input logic [XLEN-1:0] v);
        cmt_valid[l] = 1'b1;
        cmt_rd[l*REG_IDX_W +: REG_IDX_W] = REG_IDX_W'(r);
        cmt_tag[l*ROB_IDX_W +: ROB_IDX_W] = ROB_IDX_W'(t);
        cmt_val[l*XLEN +: XLEN] = v;
    endtask

    // Expected read of one slot from the architectural rules.
    task automatic exp_slot(input int s, output logic [XLEN-1:0] v,
                            output logic [ROB_IDX_W-1:0] d,
                            output logic h);
        int idx;
        idx = int'(rs_id[s*REG_IDX_W +: REG_IDX_W]);
        v = m_val[idx]; d = m_dep[idx]; h = m_hd[idx];
`ifdef RF_COMMIT_BYPASS_EN
        for (int c = 0; c < COMMIT_W; c++)
            if (cmt_valid[c] && m_hd[idx] &&
                int'(cmt_rd[c*REG_IDX_W +: REG_IDX_W]) == idx &&
                cmt_tag[c*ROB_IDX_W +: ROB_IDX_W] == m_dep[idx]) begin
                v = cmt_val[c*XLEN +: XLEN];
                h = 1'b0;
            end
`endif
        for (int j = 0; j < s / 2; j++)
            if (iss_valid[j] && idx != 0 &&
                int'(iss_rd[j*REG_IDX_W +: REG_IDX_W]) == idx) begin
                h = 1'b1;
                d = iss_tag[j*ROB_IDX_W +: ROB_IDX_W];
            end
        if (idx == 0) begin
            v = '0; d = '0; h = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [XLEN-1:0]      v;
        logic [ROB_IDX_W-1:0] d;
        logic                 h;
        int                   busy;
        for (int s = 0; s < RD_SLOTS; s++) begin
            exp_slot(s, v, d, h);
            chk($sformatf("%s.s%0d.val", tag, s),
                rs_val[s*XLEN +: XLEN], v);
            chk($sformatf("%s.s%0d.dep", tag, s),
                32'(rs_dep[s*ROB_IDX_W +: ROB_IDX_W]), 32'(d));
            chk($sformatf("%s.s%0d.hd", tag, s),
                32'(rs_has_dep[s]), 32'(h));
        end
        busy = 0;
        for (int r = 0; r < NUM_REGS; r++) busy += int'(m_hd[r]);
        chk($sformatf("%s.busy", tag), 32'(busy_cnt), 32'(busy));
    endtask

    // Next architectural state from the current inputs.
    task automatic model_update();
        logic [XLEN-1:0]      nv [NUM_REGS];
        logic [ROB_IDX_W-1:0] nd [NUM_REGS];
        logic                 nh [NUM_REGS];
        int                   r;
        nv = m_val; nd = m_dep; nh = m_hd;
        if (!rst_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                nv[i] = '0; nd[i] = '0; nh[i] = 1'b0;
            end
        end else if (rdy_in) begin
            for (int c = 0; c < COMMIT_W; c++) begin
                r = int'(cmt_rd[c*REG_IDX_W +: REG_IDX_W]);
                if (cmt_valid[c] && r != 0) begin
                    nv[r] = cmt_val[c*XLEN +: XLEN];
                    if (m_hd[r] &&
                        m_dep[r] == cmt_tag[c*ROB_IDX_W +: ROB_IDX_W]) begin
                        nh[r] = 1'b0; nd[r] = '0;
                    end
                end
            end
            for (int i = 0; i < NUM_REGS; i++)
                if (clear) begin
                    nh[i] = 1'b0; nd[i] = '0;
                end
            for (int j = 0; j < ISSUE_W; j++) begin
                r = int'(iss_rd[j*REG_IDX_W +: REG_IDX_W]);
                if (!clear && iss_valid[j] && r != 0) begin
                    nh[r] = 1'b1;
                    nd[r] = iss_tag[j*ROB_IDX_W +: ROB_IDX_W];
                end
            end
        end
        m_val = nv; m_dep = nd; m_hd = nh;
    endtask

    task automatic step(input string tag);
        #2;
        check_all(tag);
        model_update();
        @(posedge clk_in);
        #1;
    endtask

    task automatic rd_chk(input string tag, input int s, input int v,
                          input int d, input int h);
        #2;
        chk({tag, ".val"}, rs_val[s*XLEN +: XLEN], 32'(v));
        chk({tag, ".dep"}, 32'(rs_dep[s*ROB_IDX_W +: ROB_IDX_W]), 32'(d));
        chk({tag, ".hd"}, 32'(rs_has_dep[s]), 32'(h));
    endtask

    initial begin
        int r;
        for (int i = 0; i < NUM_REGS; i++) begin
            m_val[i] = '0; m_dep[i] = '0; m_hd[i] = 1'b0;
        end
        idle();
        rst_in = 1'b0;
        repeat (2) begin
            model_update();
            @(posedge clk_in);
            #1;
        end
        idle();

        for (int b = 1; b < NUM_REGS; b += RD_SLOTS) begin
            for (int s = 0; s < RD_SLOTS; s++)
                rs(s, (b + s < NUM_REGS) ? b + s : 0);
            step("rst");
        end
        chk("rst.busy0", 32'(busy_cnt), 32'd0);

        idle(); iss(0, 5, 3); step("iss5");
        idle(); rs(0, 5); rd_chk("x5.ren", 0, 0, 3, 1);
        chk("x5.busy1", 32'(busy_cnt), 32'd1);
        step("rd5");
        idle(); cmt(0, 5, 3, 32'hDEADBEEF); step("cmt5");
        idle(); rs(0, 5); rd_chk("x5.cmt", 0, 32'hDEADBEEF, 0, 0);
        chk("x5.busy0", 32'(busy_cnt), 32'd0);
        step("rd5b");

        idle(); iss(0, 7, 2); step("iss7a");
        idle(); iss(1, 7, 6); step("iss7b");
        idle(); cmt(0, 7, 2, 32'h11); step("cmt7");
        idle(); rs(0, 7); rd_chk("x7.stale", 0, 32'h11, 6, 1);
        step("rd7");

        idle(); iss(0, 9, 4); rs(2, 9); rs(0, 9);
        rd_chk("fwd.l1", 2, 0, 4, 1);
        step("fwd");
        idle(); iss(0, 9, 4); iss(1, 9, 5); step("dual9");
        idle(); rs(0, 9); rd_chk("x9.dual", 0, 0, 5, 1);
        step("rd9");

        idle(); iss(0, 3, 1); step("iss3");
        idle(); clear = 1'b1; cmt(0, 3, 7, 32'h22); iss(1, 8, 2);
        step("clr");
        idle(); rs(0, 3); rs(1, 8); rd_chk("clr.x3", 0, 32'h22, 0, 0);
        rd_chk("clr.x8", 1, 0, 0, 0);
        chk("clr.busy", 32'(busy_cnt), 32'd0);
        step("rdclr");

        idle(); iss(0, 0, 5); cmt(1, 0, 5, 32'h44); rs(2, 0);
        step("x0w");
        idle(); rs(0, 0); rd_chk("x0", 0, 0, 0, 0);
        chk("x0.busy", 32'(busy_cnt), 32'd0);
        step("rdx0");

        idle(); rdy_in = 1'b0; cmt(0, 4, 0, 32'h33); rs(0, 4);
        step("hold");
        rd_chk("hold.x4", 0, 0, 0, 0);
        rdy_in = 1'b1;
        rd_chk("resume.x4", 0, 0, 0, 0);
        step("resume");
        idle(); rs(0, 4); rd_chk("x4.late", 0, 32'h33, 0, 0);
        step("rd4");

        for (int n = 0; n < 800; n++) begin
            idle();
            rst_in = ($urandom_range(0, 199) != 0);
            rdy_in = ($urandom_range(0, 7) != 0);
            clear  = ($urandom_range(0, 19) == 0);
            for (int s = 0; s < RD_SLOTS; s++) rs(s, $urandom_range(0, 7));
            for (int l = 0; l < ISSUE_W; l++)
                if ($urandom_range(0, 1) == 1)
                    iss(l, $urandom_range(0, 7), $urandom_range(0, 15));
            for (int l = 0; l < COMMIT_W; l++)
                if ($urandom_range(0, 1) == 1) begin
                    r = $urandom_range(0, 7);
                    cmt(l, r, ($urandom_range(0, 3) != 0) ?
                        int'(m_dep[r]) : $urandom_range(0, 15), $urandom);
                end
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multi_port_register_file.md
Name: multi_port_register_file

Overview:
- Next-generation architectural register file and rename-status table for the out-of-order core.
- Holds NUM_REGS data registers. Each register carries a ROB-tag dependency (dep/has_dep).
- Serves ISSUE_W issue lanes, with two source reads and one destination rename per lane.
- Accepts COMMIT_W ROB commit lanes per cycle, and provides intra-bundle rename forwarding and a ROB flush clear.

Parameters:
- XLEN, 32, data width.
- NUM_REGS, 32, register count; register 0 is hardwired to zero.
- REG_IDX_W, 5, register index width, equal to clog2(NUM_REGS).
- ROB_IDX_W, 4, ROB tag width.
- ISSUE_W, 2, issue lanes per cycle.
- COMMIT_W, 2, commit lanes per cycle.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous, active-low reset.
- rdy_in  in  1  0 = hold all state.
- clear  in  1  ROB flush: drop all dependencies.
- rs_id  in  2*ISSUE_W*REG_IDX_W  source indices; lane k owns slots 2k and 2k+1.
- rs_val  out  2*ISSUE_W*XLEN  source values.
- rs_dep  out  2*ISSUE_W*ROB_IDX_W  producer tags.
- rs_has_dep  out  2*ISSUE_W  1 = value not yet committed.
- iss_valid  in  ISSUE_W  lane issues this cycle.
- iss_rd  in  ISSUE_W*REG_IDX_W  destination register.
- iss_tag  in  ISSUE_W*ROB_IDX_W  ROB tag of the issued instruction.
- cmt_valid  in  COMMIT_W  commit lane valid.
- cmt_rd  in  COMMIT_W*REG_IDX_W  committed destination.
- cmt_val  in  COMMIT_W*XLEN  committed value.
- cmt_tag  in  COMMIT_W*ROB_IDX_W  committed ROB tag; lane 0 is the oldest.
- busy_cnt  out  REG_IDX_W+1  number of registers with has_dep=1.

Behaviour:
- Reset (rst_in=0 at posedge): every value = 0, dep = 0, has_dep = 0, busy_cnt = 0. Reset overrides rdy_in and clear.
- rdy_in=0: no state update; combinational outputs remain valid.
- clear=1 (with rdy_in=1):
  - all dep and has_dep cleared next cycle.
  - values still accept this cycle's commits.
  - issues are ignored.
  - busy_cnt = 0 next cycle.
- Read ports are combinational, zero latency. Per slot:
  - index 0 returns val 0 and has_dep 0.
  - otherwise the stored value/dep/has_dep are the base result.
  - Intra-bundle forward: a source of lane k is matched against iss_rd of each valid lane j<k with the same index and iss_rd != 0. If any match, has_dep = 1 and dep = iss_tag of the highest such j, overriding the stored state.
- Commit, for each valid lane with cmt_rd != 0:
  - value written next cycle.
  - if two commit lanes name the same rd, the higher lane's value wins.
  - dep is cleared only if has_dep=1, stored dep == cmt_tag, and no valid issue this cycle targets that rd.
- Issue, for each valid lane with iss_rd != 0:
  - dep = iss_tag, has_dep = 1 next cycle.
  - if two issue lanes name the same rd, the higher lane wins.
  - issue always beats commit-clear on the same rd.
- Writes to register 0 are discarded on every path.
- busy_cnt is a registered population count of has_dep, updated with the same edge as the table.
- Boundary cases:
  - commit of a tag that no longer matches (register re-renamed) updates the value only.
  - all ISSUE_W lanes targeting one rd is legal.
  - commit and issue on the same rd in the same cycle leaves has_dep=1 with the new tag.

Optional Feature:
- RF_COMMIT_BYPASS_EN defined:
  - a read slot whose stored has_dep=1 and dep equals the cmt_tag of a valid same-rd commit lane returns cmt_val with has_dep=0 in the same cycle.
  - the highest matching commit lane is used.
  - intra-bundle forwarding still takes priority.
  - this removes one cycle of wakeup latency.
- Undefined: reads reflect registered state only; the committed value is visible the next cycle.

Decomposition:
- Shared package/const header holds XLEN, ROB_IDX_W, REG_IDX_W defaults and the lane-slice helper macros, in line with the existing const header.
- One natural sub-module, rf_read_port: a single source lookup with the intra-bundle forward and optional commit-bypass mux, instantiated 2*ISSUE_W times.

Test Plan:
- Reset: drive rst_in=0 for 2 cycles, then read x1..x31 -> val 0, has_dep 0, busy_cnt 0.
- Rename then commit:
  - issue rd=5, tag=3 -> next cycle rs of x5 reads has_dep 1, dep 3, busy_cnt 1.
  - commit rd=5, tag=3, val=0xDEADBEEF -> next cycle has_dep 0, val 0xDEADBEEF, busy_cnt 0.
- Stale commit: issue x7 with tag 2, then x7 with tag 6, then commit x7 tag 2 val 0x11 -> val 0x11, has_dep 1, dep 6.
- Intra-bundle forward: same cycle, lane0 issues rd=9 tag=4 and lane1 reads rs=9 -> lane1 sees has_dep 1, dep 4. Dual issue to rd=9 with tags 4 and 5 -> stored dep 5.
- Clear with commit: x3 busy, clear=1 together with commit x3 val 0x22 and an issue to x8 -> next cycle all has_dep 0, x3 = 0x22, x8 not busy.
- x0 and rdy_in:
  - issue or commit to x0 -> x0 reads 0, not busy.
  - with rdy_in=0, commit x4=0x33 -> x4 unchanged; value appears one cycle after rdy_in returns to 1.
